jtcps1_prog_sdram: RTL
======================

JTCPS1_PROG_SDRAM -- requirements
Module: jtcps1_prog_sdram

Interface
REQ-001 SHALL have parameters: INIT_WAIT=16'd10000 (power-up idle cycles); TRCD=3 and TRP=3 (cycles); TRFC=7 (cycles); TWR=2 (cycles); REF_INT=10'd750 (cycles between auto-refreshes); CAS_LAT=3'd2 (mode register CAS latency).
REQ-002 SHALL have one clock and asynchronous active-high reset, in this order: clk in 1 (system clock); rst in 1 (asynchronous, active-high reset).
REQ-003 SHALL have these ports:
- downloading in 1 (download session active)
- prog_addr in 22 (word address)
- prog_data in 16 (write data)
- prog_mask in 2 (byte mask, active low)
- prog_ba in 2 (bank)
- prog_we in 1 (level request, held until acknowledged)
- prog_rdy out 1 (one-cycle acknowledge)
- init_done out 1 (SDRAM initialised)
- sdram_a out 13 (address)
- sdram_ba out 2 (bank)
- sdram_dq out 16 (write data)
- sdram_dq_oe out 1 (data bus drive enable)
- sdram_dqm out 2 (byte masks)
- sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe out 1 each (command lines)

Function
REQ-004 SHALL decode the address as row = prog_addr[21:9] and column = prog_addr[8:0], and drive sdram_dqm = prog_mask unchanged (both active low).
REQ-005 SHALL implement states INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS, IDLE, ACT, WRITE, WR_WAIT, PRE, REFRESH.
REQ-006 In INIT_WAIT the block SHALL issue NOP for INIT_WAIT cycles, then issue PRECHARGE-ALL (A10=1) followed by TRP NOPs.
REQ-007 After the precharge, the block SHALL issue two AUTO-REFRESH commands, each followed by TRFC NOPs.
REQ-008 After the refreshes, the block SHALL issue MODE-REGISTER-SET with burst length 1, sequential, CAS_LAT and single write burst, then set init_done=1 and go to IDLE.
REQ-009 In IDLE the block SHALL accept a request when prog_we=1, init_done=1, no refresh is pending and prog_rdy was 0 in the previous cycle; on acceptance it SHALL latch address, data, mask and bank.
REQ-010 The accepted write SHALL run as: ACTIVE(row, bank), then TRCD-1 NOPs, then WRITE(column, A10=1 auto-precharge, sdram_dq_oe=1 for that single cycle), then TWR+TRP NOPs.
REQ-011 prog_rdy SHALL pulse for exactly one cycle on the last cycle of the sequence in REQ-010, and the state SHALL then return to IDLE.
REQ-012 The request-to-rdy latency SHALL be 1+TRCD+TWR+TRP cycles from the acceptance edge (9 cycles at defaults).
REQ-013 A free-running refresh counter SHALL set refresh-pending when it reaches REF_INT-1 and SHALL wrap to 0. In IDLE, a pending refresh SHALL have priority over prog_we and SHALL issue AUTO-REFRESH plus TRFC NOPs, then clear pending.
REQ-014 A refresh that becomes due during a write sequence SHALL wait; a write sequence SHALL never be interrupted.
REQ-015 A refresh due in the same cycle as a new prog_we SHALL run first; the write SHALL be accepted afterwards.
REQ-016 prog_we dropping mid-sequence SHALL NOT abort the sequence; prog_rdy SHALL still pulse.
REQ-017 Requests SHALL be ignored before init_done=1 (prog_rdy stays 0).
REQ-018 downloading SHALL NOT gate requests; it only enables refresh-count statistics and has no other effect.
REQ-019 NOP SHALL be ncs=0, nras=ncas=nwe=1; sdram_dq_oe SHALL be 0 in every cycle other than a WRITE command.

Reset
REQ-020 On rst=1, asynchronously: state=INIT_WAIT, all counters=0, init_done=0, prog_rdy=0, sdram_dq_oe=0, command=NOP, sdram_a=0, sdram_ba=0, sdram_dq=0, sdram_dqm=2'b11.
REQ-021 Reset asserted mid-write SHALL abandon the write without a prog_rdy pulse and restart the full init sequence.

Structure
REQ-022 SDRAM command encodings (NOP, ACT, WRITE, PRE, REF, MRS) and the state enumeration SHALL live in a shared package jtcps1_sdram_pkg.
REQ-023 The refresh timer SHALL be a sub-module jtcps1_sdram_reftimer (clk, rst, cnt_en, ack, pending).
REQ-024 The top level SHALL contain only the command FSM and the output registers; all outputs SHALL be registered.

Verification
REQ-025 Reset, then run INIT_WAIT=100 -> PRE-ALL at cycle 100, REF at 100+TRP and 100+TRP+TRFC, MRS with A[6:4]=2 and A[2:0]=0, then init_done=1.
REQ-026 prog_we with addr=22'h3F_F1FF, ba=2, mask=2'b10, data=16'hA5A5 -> ACT row 13'h1FF8, WRITE col 9'h1FF with A10=1, dqm=2'b10, dq=A5A5 with oe=1 for one cycle, prog_rdy 9 cycles after acceptance.
REQ-027 prog_we held high continuously across 3 writes -> exactly 3 prog_rdy pulses, one cycle idle gap after each rdy, no duplicate writes.
REQ-028 Refresh due in the same cycle as prog_we -> REF issued first, ACT 1+TRFC cycles later.
REQ-029 Refresh due during WR_WAIT -> REF issued at the first IDLE cycle after prog_rdy; no command overlap.
REQ-030 rst pulsed mid-sequence, one cycle after ACT -> no prog_rdy pulse, init_done=0, INIT sequence restarts.

Source files
------------

// File: rtl/jtcps1_sdram_pkg.sv
// Shared SDRAM command encodings, controller states and the mode-register word
// used by the CPS1 programming-port SDRAM writer.
package jtcps1_sdram_pkg;

  // {ncs, nras, ncas, nwe}
  typedef enum logic [3:0] {
    CMD_MRS   = 4'b0000,
    CMD_REF   = 4'b0001,
    CMD_PRE   = 4'b0010,
    CMD_ACT   = 4'b0011,
    CMD_WRITE = 4'b0100,
    CMD_NOP   = 4'b0111
  } sdram_cmd_e;

  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_INIT_PRE,
    ST_INIT_REF1,
    ST_INIT_REF2,
    ST_INIT_MRS,
    ST_IDLE,
    ST_ACT,
    ST_WRITE,
    ST_WR_WAIT,
    ST_PRE,
    ST_REFRESH
  } sdram_state_e;

  // Burst length 1, sequential, given CAS latency, single-location write burst (A9).
  function automatic logic [12:0] mrs_word(input logic [2:0] cas_lat);
    return {3'b000, 1'b1, 2'b00, cas_lat, 1'b0, 3'b000};
  endfunction

endpackage

// File: rtl/jtcps1_sdram_reftimer.sv
// Auto-refresh interval timer: raises pending every REF_INT enabled cycles and
// holds it until the controller acknowledges the refresh it issued.
module jtcps1_sdram_reftimer
  import jtcps1_sdram_pkg::*;
#(
  parameter logic [9:0] REF_INT = 10'd750
) (
  input  logic clk,
  input  logic rst,
  input  logic cnt_en,
  input  logic ack,
  output logic pending
);

  logic [9:0] cnt_q, cnt_d;
  logic       pending_q, pending_d;

  // A new interval expiring wins over an acknowledge landing in the same cycle.
  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    if (ack) begin
      pending_d = 1'b0;
    end
    if (cnt_en) begin
      if (cnt_q == REF_INT - 10'd1) begin
        cnt_d     = 10'd0;
        pending_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 10'd0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/jtcps1_prog_sdram.sv
// SDRAM writer for the ROM download port: power-up init, single-word writes with
// auto-precharge, and interleaved auto-refresh. All SDRAM pins come from flops.
module jtcps1_prog_sdram
  import jtcps1_sdram_pkg::*;
#(
  parameter logic [15:0] INIT_WAIT = 16'd10000,
  parameter int unsigned TRCD      = 3,
  parameter int unsigned TRP       = 3,
  parameter int unsigned TRFC      = 7,
  parameter int unsigned TWR       = 2,
  parameter logic [9:0]  REF_INT   = 10'd750,
  parameter logic [2:0]  CAS_LAT   = 3'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [21:0] prog_addr,
  input  logic [15:0] prog_data,
  input  logic [1:0]  prog_mask,
  input  logic [1:0]  prog_ba,
  input  logic        prog_we,
  output logic        prog_rdy,
  output logic        init_done,
  output logic [12:0] sdram_a,
  output logic [1:0]  sdram_ba,
  output logic [15:0] sdram_dq,
  output logic        sdram_dq_oe,
  output logic [1:0]  sdram_dqm,
  output logic        sdram_ncs,
  output logic        sdram_nras,
  output logic        sdram_ncas,
  output logic        sdram_nwe
);

  sdram_state_e state_q, state_d;
  logic [15:0]  cnt_q, cnt_d;
  sdram_cmd_e   cmd_q, cmd_d;
  logic [12:0]  a_q, a_d;
  logic [1:0]   ba_q, ba_d;
  logic [15:0]  dq_q, dq_d;
  logic         oe_q, oe_d;
  logic [1:0]   dqm_q, dqm_d;
  logic         rdy_q, rdy_d;
  logic         init_done_q, init_done_d;
  logic [21:0]  addr_q, addr_d;
  logic [15:0]  data_q, data_d;
  logic [1:0]   mask_q, mask_d;
  logic [1:0]   bank_q, bank_d;
  logic [15:0]  ref_count_q, ref_count_d;
  logic         ref_pending;
  logic         ref_ack;

  // Refresh intervals are only timed once the device is usable.
  jtcps1_sdram_reftimer #(
    .REF_INT (REF_INT)
  ) u_reftimer (
    .clk     (clk),
    .rst     (rst),
    .cnt_en  (init_done_q),
    .ack     (ref_ack),
    .pending (ref_pending)
  );

  // Each command state issues its command on entry (cnt_q == 0) and then pads
  // with NOPs; the auto-precharge recovery runs in ST_WR_WAIT then ST_PRE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = CMD_NOP;
    a_d         = a_q;
    ba_d        = ba_q;
    dq_d        = dq_q;
    oe_d        = 1'b0;
    dqm_d       = 2'b11;
    rdy_d       = 1'b0;
    init_done_d = init_done_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mask_d      = mask_q;
    bank_d      = bank_q;
    ref_ack     = 1'b0;
    ref_count_d = ref_count_q;

    case (state_q)
      ST_INIT_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == INIT_WAIT - 16'd1) begin
          state_d = ST_INIT_PRE;
          cnt_d   = 16'd0;
        end
      end
      ST_INIT_PRE: begin
        if (cnt_q == 16'd0) begin
          cmd_d = CMD_PRE;
          a_d   = 13'h0400;
        end
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(TRP - 1)) begin
          state_d = ST_INIT_REF1;
          cnt_d   = 16'd0;
        end
      end
      ST_INIT_REF1, ST_INIT_REF2: begin
        if (cnt_q == 16'd0) begin
          cmd_d = CMD_REF;
        end
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(TRFC - 1)) begin
          state_d = (state_q == ST_INIT_REF1) ? ST_INIT_REF2 : ST_INIT_MRS;
          cnt_d   = 16'd0;
        end
      end
      ST_INIT_MRS: begin
        cmd_d       = CMD_MRS;
        a_d         = mrs_word(CAS_LAT);
        ba_d        = 2'b00;
        init_done_d = 1'b1;
        state_d     = ST_IDLE;
        cnt_d       = 16'd0;
      end
      ST_IDLE: begin
        cnt_d = 16'd0;
        if (ref_pending) begin
          cmd_d   = CMD_REF;
          ref_ack = 1'b1;
          state_d = ST_REFRESH;
          if (downloading) begin
            ref_count_d = ref_count_q + 16'd1;
          end
        end else if (prog_we && init_done_q && !rdy_q) begin
          addr_d  = prog_addr;
          data_d  = prog_data;
          mask_d  = prog_mask;
          bank_d  = prog_ba;
          state_d = ST_ACT;
        end
      end
      ST_ACT: begin
        if (cnt_q == 16'd0) begin
          cmd_d = CMD_ACT;
          a_d   = addr_q[21:9];
          ba_d  = bank_q;
        end
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(TRCD - 1)) begin
          state_d = ST_WRITE;
          cnt_d   = 16'd0;
        end
      end
      ST_WRITE: begin
        cmd_d   = CMD_WRITE;
        a_d     = {2'b00, 1'b1, 1'b0, addr_q[8:0]};
        ba_d    = bank_q;
        dq_d    = data_q;
        oe_d    = 1'b1;
        dqm_d   = mask_q;
        state_d = ST_WR_WAIT;
        cnt_d   = 16'd0;
      end
      ST_WR_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(TWR - 1)) begin
          state_d = ST_PRE;
          cnt_d   = 16'd0;
        end
      end
      ST_PRE: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(TRP - 1)) begin
          rdy_d   = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end
      end
      ST_REFRESH: begin
        // The REF itself went out from IDLE, so one fewer padding NOP here.
        cnt_d = cnt_q + 16'd1;
        if (cnt_q + 16'd2 >= 16'(TRFC)) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end
      end
      default: begin
        state_d = ST_INIT_WAIT;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT_WAIT;
      cnt_q       <= 16'd0;
      cmd_q       <= CMD_NOP;
      a_q         <= 13'd0;
      ba_q        <= 2'd0;
      dq_q        <= 16'd0;
      oe_q        <= 1'b0;
      dqm_q       <= 2'b11;
      rdy_q       <= 1'b0;
      init_done_q <= 1'b0;
      addr_q      <= 22'd0;
      data_q      <= 16'd0;
      mask_q      <= 2'b11;
      bank_q      <= 2'd0;
      ref_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      a_q         <= a_d;
      ba_q        <= ba_d;
      dq_q        <= dq_d;
      oe_q        <= oe_d;
      dqm_q       <= dqm_d;
      rdy_q       <= rdy_d;
      init_done_q <= init_done_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      bank_q      <= bank_d;
      ref_count_q <= ref_count_d;
    end
  end

  assign {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe} = cmd_q;
  assign sdram_a     = a_q;
  assign sdram_ba    = ba_q;
  assign sdram_dq    = dq_q;
  assign sdram_dq_oe = oe_q;
  assign sdram_dqm   = dqm_q;
  assign prog_rdy    = rdy_q;
  assign init_done   = init_done_q;

endmodule
